// File: rtl/instr_prefetch_queue_if.sv
// Handshake bundle between the QSPI prefetcher/decoder (master) and the
// instruction prefetch queue (slave).
interface instr_prefetch_queue_if #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 6
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             pop;
  logic             flush;
  logic [CW-1:0]    count;
  logic             almost_full;
  logic             empty;

  modport master (
    output in_data, in_valid, pop, flush,
    input  in_ready, out_data, out_valid, count, almost_full, empty
  );

  modport slave (
    input  in_data, in_valid, pop, flush,
    output in_ready, out_data, out_valid, count, almost_full, empty
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Self-compacting DEPTH-stage instruction prefetch chain: stage 0 is the tail,
// stage DEPTH-1 the head; invalid slots are refilled from behind every edge.
module instr_prefetch_queue #(
  parameter int WIDTH     = 18,
  parameter int DEPTH     = 6,
  parameter int AF_THRESH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  instr_prefetch_queue_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic [WIDTH-1:0] data_d  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [DEPTH-1:0] mv;
  logic             in_ready;
  logic             push;
  logic             pop_hit;

  // A stage may advance if it is empty or everything ahead of it advances.
  always_comb begin
    mv            = '0;
    mv[DEPTH-1]   = bus.pop | ~valid_q[DEPTH-1];
    for (int unsigned k = 1; k < DEPTH; k++) begin
      mv[DEPTH-1-k] = ~valid_q[DEPTH-1-k] | mv[DEPTH-k];
    end
  end

  assign in_ready = mv[0] & ~bus.flush;
  assign push     = bus.in_valid & in_ready;
  assign pop_hit  = bus.pop & valid_q[DEPTH-1];

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (mv[i]) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end
    if (mv[0]) begin
      data_d[0]  = bus.in_data;
      valid_d[0] = push;
    end
    if (bus.flush) begin
      valid_d = '0;
    end
  end

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop_hit);
    if (bus.flush) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Status flags decode the registered count, not the valid bits.
  assign bus.in_ready    = in_ready;
  assign bus.out_data    = data_q[DEPTH-1];
  assign bus.out_valid   = valid_q[DEPTH-1];
  assign bus.count       = count_q;
  assign bus.almost_full = (count_q >= CW'(AF_THRESH));
  assign bus.empty       = (count_q == '0);
endmodule
